// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the execute stage: ALU op codes, opcodes,
// branch funct3 values, forwarding selects and the bubble instruction.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b1000,
        ALU_SLL   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_SRA   = 4'b1101,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111,
        ALU_PASSB = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG     = 2'b00,
        FWD_MA      = 2'b01,
        FWD_WB      = 2'b10,
        FWD_REG_ALT = 2'b11
    } fwd_sel_e;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // JALR targets are always halfword-aligned: bit 0 of the sum is dropped.
    function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] sum);
        return {sum[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Decode/hazard-side inputs and MA-side outputs of the execute stage.
interface ex_stage_if;
    import rv32_pkg::*;

    logic            stall;
    logic            flush;
    logic [XLEN-1:0] pc_Ex;
    logic [31:0]     inst_Ex;
    logic [XLEN-1:0] rs1_Ex;
    logic [XLEN-1:0] rs2_Ex;
    logic [XLEN-1:0] imm_Ex;
    logic            a_sel;
    logic            b_sel;
    logic [3:0]      alu_op;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [XLEN-1:0] fwd_ma_data;
    logic [XLEN-1:0] fwd_wb_data;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc_Ma;
    logic [XLEN-1:0] alu_out_Ma;
    logic [XLEN-1:0] rs2_Ma;
    logic [31:0]     inst_Ma;
    logic            valid_Ma;

    modport slave (
        input  stall, flush, pc_Ex, inst_Ex, rs1_Ex, rs2_Ex, imm_Ex,
               a_sel, b_sel, alu_op, fwd_a, fwd_b, fwd_ma_data, fwd_wb_data,
        output br_taken, br_target, pc_Ma, alu_out_Ma, rs2_Ma, inst_Ma, valid_Ma
    );

    modport master (
        output stall, flush, pc_Ex, inst_Ex, rs1_Ex, rs2_Ex, imm_Ex,
               a_sel, b_sel, alu_op, fwd_a, fwd_b, fwd_ma_data, fwd_wb_data,
        input  br_taken, br_target, pc_Ma, alu_out_Ma, rs2_Ma, inst_Ma, valid_Ma
    );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU; unknown op codes produce zero.
module alu
    import rv32_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_op,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt_s;

    assign shamt_s = b[4:0];

    // Operation select
    always_comb begin
        y = {XLEN{1'b0}};
        case (alu_op)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt_s;
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt_s;
            ALU_SRA:   y = $unsigned($signed(a) >>> shamt_s);
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution
// and the EX->MA pipeline register.
module ex_stage
    import rv32_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    ex_stage_if.slave bus
);

    logic [XLEN-1:0] fwd_rs1_s;
    logic [XLEN-1:0] fwd_rs2_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [XLEN-1:0] alu_y_s;
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            cond_s;
    logic            taken_raw_s;
    logic [XLEN-1:0] pc_ma_r;
    logic [XLEN-1:0] alu_out_ma_r;
    logic [XLEN-1:0] rs2_ma_r;
    logic [31:0]     inst_ma_r;
    logic            valid_ma_r;

    assign opcode_s = bus.inst_Ex[6:0];
    assign funct3_s = bus.inst_Ex[14:12];

    // Forwarding muxes; select 11 falls back to the register file value
    always_comb begin
        case (bus.fwd_a)
            FWD_MA:  fwd_rs1_s = bus.fwd_ma_data;
            FWD_WB:  fwd_rs1_s = bus.fwd_wb_data;
            default: fwd_rs1_s = bus.rs1_Ex;
        endcase
        case (bus.fwd_b)
            FWD_MA:  fwd_rs2_s = bus.fwd_ma_data;
            FWD_WB:  fwd_rs2_s = bus.fwd_wb_data;
            default: fwd_rs2_s = bus.rs2_Ex;
        endcase
    end

    assign op_a_s = bus.a_sel ? bus.pc_Ex  : fwd_rs1_s;
    assign op_b_s = bus.b_sel ? bus.imm_Ex : fwd_rs2_s;

    alu u_alu (
        .a      (op_a_s),
        .b      (op_b_s),
        .alu_op (bus.alu_op),
        .y      (alu_y_s)
    );

    // Branch condition on the forwarded register operands
    always_comb begin
        cond_s = 1'b0;
        case (funct3_s)
            F3_BEQ:  cond_s = (fwd_rs1_s == fwd_rs2_s);
            F3_BNE:  cond_s = (fwd_rs1_s != fwd_rs2_s);
            F3_BLT:  cond_s = ($signed(fwd_rs1_s) <  $signed(fwd_rs2_s));
            F3_BGE:  cond_s = ($signed(fwd_rs1_s) >= $signed(fwd_rs2_s));
            F3_BLTU: cond_s = (fwd_rs1_s <  fwd_rs2_s);
            F3_BGEU: cond_s = (fwd_rs1_s >= fwd_rs2_s);
            default: cond_s = 1'b0;
        endcase
    end

    // Control-flow decision and redirect address
    always_comb begin
        taken_raw_s = 1'b0;
        case (opcode_s)
            OP_BRANCH: taken_raw_s = cond_s;
            OP_JAL:    taken_raw_s = 1'b1;
            OP_JALR:   taken_raw_s = 1'b1;
            default:   taken_raw_s = 1'b0;
        endcase
        if (opcode_s == OP_JALR) begin
            bus.br_target = jalr_target(alu_y_s);
        end else begin
            bus.br_target = alu_y_s;
        end
    end

    // A stalled or bubbled EX slot must never redirect fetch
    assign bus.br_taken = taken_raw_s & ~bus.stall & (bus.inst_Ex != NOP_INST);

    // EX->MA register: reset > flush > stall > load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_ma_r      <= {XLEN{1'b0}};
            alu_out_ma_r <= {XLEN{1'b0}};
            rs2_ma_r     <= {XLEN{1'b0}};
            inst_ma_r    <= NOP_INST;
            valid_ma_r   <= 1'b0;
        end else if (bus.flush) begin
            pc_ma_r      <= {XLEN{1'b0}};
            alu_out_ma_r <= {XLEN{1'b0}};
            rs2_ma_r     <= {XLEN{1'b0}};
            inst_ma_r    <= NOP_INST;
            valid_ma_r   <= 1'b0;
        end else if (bus.stall) begin
            pc_ma_r      <= pc_ma_r;
            alu_out_ma_r <= alu_out_ma_r;
            rs2_ma_r     <= rs2_ma_r;
            inst_ma_r    <= inst_ma_r;
            valid_ma_r   <= valid_ma_r;
        end else begin
            pc_ma_r      <= bus.pc_Ex;
            alu_out_ma_r <= alu_y_s;
            rs2_ma_r     <= fwd_rs2_s;
            inst_ma_r    <= bus.inst_Ex;
            valid_ma_r   <= 1'b1;
        end
    end

    assign bus.pc_Ma      = pc_ma_r;
    assign bus.alu_out_Ma = alu_out_ma_r;
    assign bus.rs2_Ma     = rs2_ma_r;
    assign bus.inst_Ma    = inst_ma_r;
    assign bus.valid_Ma   = valid_ma_r;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: vector table plus scoreboard of MA-register
// expectations, followed by stall, flush and asynchronous-reset sequences.
module tb_ex_stage;
    import rv32_pkg::*;

    localparam logic [31:0] R_INST    = 32'h0000_0033;
    localparam logic [31:0] JAL_INST  = 32'h0000_006F;
    localparam logic [31:0] JALR_INST = 32'h0000_0067;
    localparam logic [31:0] LUI_INST  = 32'h0000_0037;

    typedef struct {
        logic [31:0] pc, inst, rs1, rs2, imm;
        logic        a_sel, b_sel;
        logic [3:0]  op;
        logic [1:0]  fa, fb;
        logic [31:0] ma, wb;
        logic [31:0] exp_alu, exp_rs2;
        logic        exp_taken;
        logic [31:0] exp_tgt;
    } vec_t;

    typedef struct {
        logic [31:0] pc, alu, rs2, inst;
        logic        valid;
    } ma_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    vec_t vecs[$];
    ma_t  sb[$];

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] br_inst(input logic [2:0] f3);
        return {17'h0_0000, f3, 5'b00000, 7'b1100011};
    endfunction

    function automatic vec_t mk(input logic [31:0] pc, inst, rs1, rs2, imm,
                                input logic a_sel, b_sel, input logic [3:0] op,
                                input logic [1:0] fa, fb, input logic [31:0] ma, wb,
                                input logic [31:0] exp_alu, exp_rs2,
                                input logic exp_taken, input logic [31:0] exp_tgt);
        vec_t v;
        v.pc = pc; v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.a_sel = a_sel; v.b_sel = b_sel; v.op = op; v.fa = fa; v.fb = fb;
        v.ma = ma; v.wb = wb; v.exp_alu = exp_alu; v.exp_rs2 = exp_rs2;
        v.exp_taken = exp_taken; v.exp_tgt = exp_tgt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.pc_Ex = v.pc; bus.inst_Ex = v.inst; bus.rs1_Ex = v.rs1; bus.rs2_Ex = v.rs2;
        bus.imm_Ex = v.imm; bus.a_sel = v.a_sel; bus.b_sel = v.b_sel; bus.alu_op = v.op;
        bus.fwd_a = v.fa; bus.fwd_b = v.fb; bus.fwd_ma_data = v.ma; bus.fwd_wb_data = v.wb;
    endtask

    task automatic push_load(input vec_t v);
        ma_t e;
        e.pc = v.pc; e.alu = v.exp_alu; e.rs2 = v.exp_rs2; e.inst = v.inst; e.valid = 1'b1;
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        ma_t e;
        e.pc = 32'h0; e.alu = 32'h0; e.rs2 = 32'h0; e.inst = NOP_INST; e.valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic check_ma(input string tag);
        ma_t e;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " pc_Ma"},      bus.pc_Ma,      e.pc);
            check({tag, " alu_out_Ma"}, bus.alu_out_Ma, e.alu);
            check({tag, " rs2_Ma"},     bus.rs2_Ma,     e.rs2);
            check({tag, " inst_Ma"},    bus.inst_Ma,    e.inst);
            check({tag, " valid_Ma"},   {31'h0, bus.valid_Ma}, {31'h0, e.valid});
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        drive(v);
        #1;
        check({tag, " br_taken"}, {31'h0, bus.br_taken}, {31'h0, v.exp_taken});
        if (v.exp_taken) check({tag, " br_target"}, bus.br_target, v.exp_tgt);
        push_load(v);
        @(posedge clk);
        #1;
        check_ma(tag);
    endtask

    initial begin
        vec_t v;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(mk(32'h0, NOP_INST, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 2'b00, 2'b00,
                 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0));

        vecs.push_back(mk(32'h10, R_INST, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'd12, 32'd7, 1'b0, 32'h0));
        vecs.push_back(mk(32'h14, R_INST, 32'h8000_0000, 32'd33, 32'h0, 1'b0, 1'b0, ALU_SRA, 2'b00, 2'b00, 32'h0, 32'h0, 32'hC000_0000, 32'd33, 1'b0, 32'h0));
        vecs.push_back(mk(32'h18, R_INST, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, ALU_SLTU, 2'b00, 2'b00, 32'h0, 32'h0, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h0));
        vecs.push_back(mk(32'h1C, R_INST, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, ALU_SLT, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 32'hFFFF_FFFF, 1'b0, 32'h0));
        vecs.push_back(mk(32'h20, R_INST, 32'd0, 32'd55, 32'd4, 1'b0, 1'b1, ALU_ADD, 2'b01, 2'b10, 32'd100, 32'd9, 32'd104, 32'd9, 1'b0, 32'h0));
        vecs.push_back(mk(32'h24, R_INST, 32'd20, 32'd3, 32'h0, 1'b0, 1'b0, ALU_SUB, 2'b11, 2'b11, 32'hAAAA, 32'hBBBB, 32'd17, 32'd3, 1'b0, 32'h0));
        vecs.push_back(mk(32'h28, R_INST, 32'hFFFF_FFFF, 32'd2, 32'h0, 1'b0, 1'b0, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'd1, 32'd2, 1'b0, 32'h0));
        vecs.push_back(mk(32'h40, br_inst(3'b100), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h38, 32'd1, 1'b1, 32'h38));
        vecs.push_back(mk(32'h40, br_inst(3'b110), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h38, 32'd1, 1'b0, 32'h0));
        vecs.push_back(mk(32'h40, br_inst(3'b000), 32'd5, 32'd5, 32'hFFFF_FFF8, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h38, 32'd5, 1'b1, 32'h38));
        vecs.push_back(mk(32'h40, br_inst(3'b001), 32'd5, 32'd5, 32'hFFFF_FFF8, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h38, 32'd5, 1'b0, 32'h0));
        vecs.push_back(mk(32'h40, br_inst(3'b101), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h38, 32'd1, 1'b0, 32'h0));
        vecs.push_back(mk(32'h40, br_inst(3'b111), 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h38, 32'd1, 1'b1, 32'h38));
        vecs.push_back(mk(32'h40, br_inst(3'b010), 32'd5, 32'd5, 32'hFFFF_FFF8, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h38, 32'd5, 1'b0, 32'h0));
        vecs.push_back(mk(32'h60, br_inst(3'b100), 32'd0, 32'd0, 32'h10, 1'b1, 1'b1, ALU_ADD, 2'b10, 2'b01, 32'd3, 32'hFFFF_FFFE, 32'h70, 32'd3, 1'b1, 32'h70));
        vecs.push_back(mk(32'h80, JALR_INST, 32'h103, 32'hDEAD, 32'h0, 1'b0, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h103, 32'hDEAD, 1'b1, 32'h102));
        vecs.push_back(mk(32'h100, JAL_INST, 32'h0, 32'h0, 32'h20, 1'b1, 1'b1, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'h120, 32'h0, 1'b1, 32'h120));
        vecs.push_back(mk(32'h104, LUI_INST, 32'h5, 32'h0, 32'h1234_5000, 1'b0, 1'b1, ALU_PASSB, 2'b00, 2'b00, 32'h0, 32'h0, 32'h1234_5000, 32'h0, 1'b0, 32'h0));
        vecs.push_back(mk(32'h108, R_INST, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b0, 1'b0, ALU_XOR, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 32'h0));
        vecs.push_back(mk(32'h10C, R_INST, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b0, 1'b0, ALU_OR, 2'b00, 2'b00, 32'h0, 32'h0, 32'hFFF0_FFF0, 32'hFF00_FF00, 1'b0, 32'h0));
        vecs.push_back(mk(32'h110, R_INST, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 1'b0, 1'b0, ALU_AND, 2'b00, 2'b00, 32'h0, 32'h0, 32'hF000_F000, 32'hFF00_FF00, 1'b0, 32'h0));
        vecs.push_back(mk(32'h114, R_INST, 32'd1, 32'h24, 32'h0, 1'b0, 1'b0, ALU_SLL, 2'b00, 2'b00, 32'h0, 32'h0, 32'h10, 32'h24, 1'b0, 32'h0));
        vecs.push_back(mk(32'h118, R_INST, 32'h8000_0000, 32'd31, 32'h0, 1'b0, 1'b0, ALU_SRL, 2'b00, 2'b00, 32'h0, 32'h0, 32'd1, 32'd31, 1'b0, 32'h0));
        vecs.push_back(mk(32'h11C, R_INST, 32'd9, 32'd4, 32'h0, 1'b0, 1'b0, 4'b1001, 2'b00, 2'b00, 32'h0, 32'h0, 32'd0, 32'd4, 1'b0, 32'h0));
        vecs.push_back(mk(32'h120, NOP_INST, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, ALU_ADD, 2'b00, 2'b00, 32'h0, 32'h0, 32'd7, 32'd4, 1'b0, 32'h0));

        // Reset values, checked while reset is still asserted
        #2;
        push_bubble();
        check_ma("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Stall three cycles: MA registers hold, JALR in EX must not redirect
        apply(vecs[0], "pre_stall");
        bus.stall = 1'b1;
        drive(vecs[15]);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("stall%0d br_taken", k), {31'h0, bus.br_taken}, 32'h0);
            push_load(vecs[0]);
            @(posedge clk);
            #1;
            check_ma($sformatf("stall%0d", k));
        end
        bus.stall = 1'b0;
        apply(vecs[15], "post_stall");

        // Flush wins over stall
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(vecs[1]);
        push_bubble();
        @(posedge clk);
        #1;
        check_ma("flush_stall");
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        apply(vecs[1], "post_flush");

        // Asynchronous reset mid-stall, then first unstalled edge loads
        bus.stall = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        push_bubble();
        check_ma("async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.stall = 1'b0;
        apply(vecs[4], "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
